control_decode: RTL and testbench

CONTROL_DECODE -- requirements
Module: control_decode

---
 rtl/control_decode_pkg.sv | 72 +++++++
 rtl/control_decode_prio.sv | 20 ++
 rtl/control_decode.sv | 119 +++++++++++
 tb/tb_control_decode.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/control_decode_pkg.sv
// Shared encodings for the instruction-class control decoder: output field
// codes, class indices and the packed control bundle.
package control_decode_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_U = 2'b10
  } imm_sel_e;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_PC   = 2'b01,
    OPA_PC4  = 2'b10,
    OPA_ZERO = 2'b11
  } opa_e;

  typedef enum logic [1:0] {
    NPC_PC4  = 2'b00,
    NPC_BR   = 2'b01,
    NPC_JAL  = 2'b10,
    NPC_JALR = 2'b11
  } npc_e;

  typedef enum logic [2:0] {
    ALU_R   = 3'b000,
    ALU_I   = 3'b001,
    ALU_B   = 3'b010,
    ALU_J   = 3'b011,
    ALU_L   = 3'b100,
    ALU_S   = 3'b101,
    ALU_LUI = 3'b110,
    ALU_AUI = 3'b111
  } alu_e;

  typedef enum logic [3:0] {
    SEL_ADD    = 4'b0000,
    SEL_SUB    = 4'b1000,
    SEL_PASS_B = 4'b1110,
    SEL_PASS_A = 4'b1111
  } alu_sel_e;

  // Class vector bit positions; a higher index wins in the priority encoder.
  localparam int unsigned NUM_CLS = 9;
  localparam int unsigned CLS_R   = 0;
  localparam int unsigned CLS_I   = 1;
  localparam int unsigned CLS_L   = 2;
  localparam int unsigned CLS_S   = 3;
  localparam int unsigned CLS_B   = 4;
  localparam int unsigned CLS_J   = 5;
  localparam int unsigned CLS_JR  = 6;
  localparam int unsigned CLS_AUI = 7;
  localparam int unsigned CLS_LUI = 8;

  typedef logic [NUM_CLS-1:0] cls_t;

  typedef struct packed {
    logic     reg_write;
    logic     branch;
    logic     op_b;
    logic     store;
    logic     mem_to_reg;
    imm_sel_e imm_sel;
    opa_e     op_a;
    npc_e     next_pc;
    alu_e     alu;
    alu_sel_e alu_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode_prio.sv
// Fixed-priority resolver: keeps only the highest-index asserted class flag.
module control_decode_prio
  import control_decode_pkg::*;
(
  input  logic [NUM_CLS-1:0] flags,
  output logic [NUM_CLS-1:0] onehot
);

  // Ascending scan so the last (highest-priority) asserted flag overwrites.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_CLS; i++) begin
      if (flags[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_decode.sv
// Instruction-class control decoder: priority-resolve the class flags, look
// up the control bundle and register it with an async active-high reset.
module control_decode
  import control_decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       R,
  input  logic       I,
  input  logic       L,
  input  logic       S,
  input  logic       B,
  input  logic       J,
  input  logic       Jr,
  input  logic       lui,
  input  logic       aui,
  output logic       regWrite,
  output logic       branch,
  output logic       opB,
  output logic       store,
  output logic       memToReg,
  output logic [1:0] immSel,
  output logic [1:0] opA,
  output logic [1:0] nextPc,
  output logic [2:0] alu,
  output logic [3:0] aluSel
);

  cls_t  flags;
  cls_t  cls;
  ctrl_t d;
  ctrl_t q;

  assign flags = {lui, aui, Jr, J, B, S, L, I, R};

  control_decode_prio u_prio (
    .flags  (flags),
    .onehot (cls)
  );

  always_comb begin
    d = CTRL_NOP;
    case (1'b1)
      cls[CLS_LUI]: begin
        d.reg_write = 1'b1;
        d.op_a      = OPA_ZERO;
        d.op_b      = 1'b1;
        d.imm_sel   = IMM_U;
        d.alu       = ALU_LUI;
        d.alu_sel   = SEL_PASS_B;
      end
      cls[CLS_AUI]: begin
        d.reg_write = 1'b1;
        d.op_a      = OPA_PC;
        d.op_b      = 1'b1;
        d.imm_sel   = IMM_U;
        d.alu       = ALU_AUI;
      end
      cls[CLS_JR]: begin
        d.reg_write = 1'b1;
        d.op_a      = OPA_PC4;
        d.next_pc   = NPC_JALR;
        d.alu       = ALU_J;
        d.alu_sel   = SEL_PASS_A;
      end
      cls[CLS_J]: begin
        d.reg_write = 1'b1;
        d.op_a      = OPA_PC4;
        d.next_pc   = NPC_JAL;
        d.alu       = ALU_J;
        d.alu_sel   = SEL_PASS_A;
      end
      cls[CLS_B]: begin
        d.branch  = 1'b1;
        d.next_pc = NPC_BR;
        d.alu     = ALU_B;
        d.alu_sel = SEL_SUB;
      end
      cls[CLS_S]: begin
        d.store   = 1'b1;
        d.op_b    = 1'b1;
        d.imm_sel = IMM_S;
        d.alu     = ALU_S;
      end
      cls[CLS_L]: begin
        d.reg_write  = 1'b1;
        d.mem_to_reg = 1'b1;
        d.op_b       = 1'b1;
        d.alu        = ALU_L;
      end
      cls[CLS_I]: begin
        d.reg_write = 1'b1;
        d.op_b      = 1'b1;
        d.alu       = ALU_I;
      end
      cls[CLS_R]: begin
        d.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= CTRL_NOP;
    else     q <= d;
  end

  assign regWrite = q.reg_write;
  assign branch   = q.branch;
  assign opB      = q.op_b;
  assign store    = q.store;
  assign memToReg = q.mem_to_reg;
  assign immSel   = q.imm_sel;
  assign opA      = q.op_a;
  assign nextPc   = q.next_pc;
  assign alu      = q.alu;
  assign aluSel   = q.alu_sel;

endmodule

// File: tb/tb_control_decode.sv
// Randomized self-checking bench for control_decode against a table-driven
// reference model, plus literal directed expectations.
module tb_control_decode;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] f = '0;  // {lui, aui, Jr, J, B, S, L, I, R}

  logic       regWrite, branch, opB, store, memToReg;
  logic [1:0] immSel, opA, nextPc;
  logic [2:0] alu;
  logic [3:0] aluSel;

  logic [17:0] dut_bus;
  logic [17:0] exp_bus;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 if (clk_en) clk = ~clk;

  control_decode dut (
    .clk      (clk),
    .rst      (rst),
    .R        (f[0]),
    .I        (f[1]),
    .L        (f[2]),
    .S        (f[3]),
    .B        (f[4]),
    .J        (f[5]),
    .Jr       (f[6]),
    .aui      (f[7]),
    .lui      (f[8]),
    .regWrite (regWrite),
    .branch   (branch),
    .opB      (opB),
    .store    (store),
    .memToReg (memToReg),
    .immSel   (immSel),
    .opA      (opA),
    .nextPc   (nextPc),
    .alu      (alu),
    .aluSel   (aluSel)
  );

  assign dut_bus = {regWrite, branch, opB, store, memToReg, immSel, opA, nextPc, alu, aluSel};

  function automatic logic [17:0] pk(input bit rw, input bit br, input bit ob, input bit st,
                                     input bit mr, input bit [1:0] imm, input bit [1:0] oa,
                                     input bit [1:0] npc, input bit [2:0] a, input bit [3:0] s);
    return {rw, br, ob, st, mr, imm, oa, npc, a, s};
  endfunction

  // Outputs for a single winning class, written straight from the class table.
  function automatic logic [17:0] row(input int k);
    case (k)
      0: return pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0);   // R
      1: return pk(1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd1, 4'd0);   // I
      2: return pk(1, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, 3'd4, 4'd0);   // L
      3: return pk(0, 0, 1, 1, 0, 2'd1, 2'd0, 2'd0, 3'd5, 4'd0);   // S
      4: return pk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd2, 4'd8);   // B
      5: return pk(1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd3, 4'd15);  // J
      6: return pk(1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd3, 3'd3, 4'd15);  // Jr
      7: return pk(1, 0, 1, 0, 0, 2'd2, 2'd1, 2'd0, 3'd7, 4'd0);   // aui
      8: return pk(1, 0, 1, 0, 0, 2'd2, 2'd3, 2'd0, 3'd6, 4'd14);  // lui
      default: return '0;
    endcase
  endfunction

  function automatic logic [17:0] model(input logic [8:0] fl);
    int prio_order[9] = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
    foreach (prio_order[p]) begin
      if (fl[prio_order[p]]) return row(prio_order[p]);
    end
    return '0;
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b required %b (t=%0t)", name, act, req, $time);
  endtask

  // One clock cycle: model latches the flags seen at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    exp_bus = rst ? 18'd0 : model(f);
    #1;
    check("cycle", dut_bus, exp_bus);
  endtask

  task automatic step(input logic [8:0] fl, input string name, input logic [17:0] lit);
    f = fl;
    cycle();
    check(name, dut_bus, lit);
  endtask

  initial begin
    // Reset must clear outputs with the clock stopped.
    #2 f = 9'b0_0000_0001;
    #1 rst = 1'b1;
    exp_bus = '0;
    #1 check("reset_no_clk", dut_bus, 18'd0);

    clk_en = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    step(9'b0_0000_0001, "R",  pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0));
    step(9'b0_0000_0010, "I",  pk(1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd1, 4'd0));
    step(9'b0_0000_0100, "L",  pk(1, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, 3'd4, 4'd0));
    step(9'b0_0000_1000, "S",  pk(0, 0, 1, 1, 0, 2'd1, 2'd0, 2'd0, 3'd5, 4'd0));
    step(9'b0_0001_0000, "B",  pk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd2, 4'd8));
    step(9'b0_0010_0000, "J",  pk(1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd3, 4'd15));
    step(9'b0_0100_0000, "Jr", pk(1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd3, 3'd3, 4'd15));
    step(9'b1_0000_0001, "R_plus_lui", pk(1, 0, 1, 0, 0, 2'd2, 2'd3, 2'd0, 3'd6, 4'd14));
    step(9'b0_1000_0000, "aui", pk(1, 0, 1, 0, 0, 2'd2, 2'd1, 2'd0, 3'd7, 4'd0));
    step(9'b0_0000_0000, "nop_after_aui", 18'd0);
    step(9'b0_0111_1110, "Jr_over_lower", pk(1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd3, 3'd3, 4'd15));
    step(9'b0_0001_1100, "B_over_S_L", pk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'd2, 4'd8));

    // Reset asserted mid-stream discards the pending decode.
    step(9'b0_0000_0001, "R_pre_rst", pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0));
    f = 9'b0_0000_0010;
    #2 rst = 1'b1;
    exp_bus = '0;
    #1 check("rst_mid", dut_bus, 18'd0);
    cycle();
    check("rst_held", dut_bus, 18'd0);
    rst = 1'b0;
    step(9'b0_0000_0010, "I_after_rst", pk(1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd1, 4'd0));

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       f = '0;
        1, 2, 3: f = 9'($urandom) & 9'($urandom);
        default: f = 9'(1) << $urandom_range(0, 8);
      endcase
      if ($urandom_range(0, 24) == 0) begin
        #($urandom_range(1, 3)) rst = 1'b1;
        exp_bus = '0;
        #1 check("async_rst", dut_bus, 18'd0);
        cycle();
        rst = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

endmodule
